// File: rtl/kontrolli_mbledhesit_serik.sv
// Bit-serial add/subtract sequencer. One external full-adder cell is reused
// for WIDTH cycles, starting from the LSB, to build a WIDTH-bit result and its flags.
module kontrolli_mbledhesit_serik #(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic             Start,
  input  logic             Sub,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  output logic             FA_A,
  output logic             FA_B,
  output logic             FA_CIN,
  input  logic             FA_Shuma,
  input  logic             FA_COUT,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             COUT,
  output logic             Overflow,
  output logic             Zero,
  output logic [1:0]       dbg_state_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  // Handshake: Start is accepted only in ST_IDLE or ST_DONE. Done is high for
  // exactly one cycle. Start is ignored while Busy is high.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             run;
  logic             accept;
  logic [WIDTH-1:0] shifted_result;

  assign run            = (state_q == ST_RUN);
  assign accept         = Start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign shifted_result = {FA_Shuma, result_q[WIDTH-1:1]};

  // The cell sees live operand bits only while running. Otherwise it sees 0.
  assign FA_A   = run & sa_q[0];
  assign FA_B   = run & sb_q[0];
  assign FA_CIN = run & carry_q;

  assign Busy        = run;
  assign Done        = (state_q == ST_DONE);
  assign Result      = result_q;
  assign COUT        = cout_q;
  assign Overflow    = ovf_q;
  assign Zero        = zero_q;
  assign dbg_state_o = state_q;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q  <= ST_IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    case (state_q)
      ST_RUN: begin
        sa_d     = sa_q >> 1;
        sb_d     = sb_q >> 1;
        result_d = shifted_result;
        carry_d  = FA_COUT;
        if (cnt_q == LAST_BIT) begin
          // Overflow is the carry into the MSB XOR the carry out of the MSB.
          cout_d  = FA_COUT;
          ovf_d   = FA_CIN ^ FA_COUT;
          zero_d  = (shifted_result == '0);
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Subtraction is A + ~B + 1: invert B here and start with the carry set.
    if (accept) begin
      sa_d     = OpA;
      sb_d     = OpB ^ {WIDTH{Sub}};
      carry_d  = Sub;
      cnt_d    = '0;
      result_d = '0;
      cout_d   = 1'b0;
      ovf_d    = 1'b0;
      zero_d   = 1'b0;
      state_d  = ST_RUN;
    end
  end

endmodule

// File: tb/tb_kontrolli_mbledhesit_serik.sv
// Directed bench for the bit-serial add/subtract sequencer. An ideal
// full-adder cell is modelled combinationally around the DUT.
module tb_kontrolli_mbledhesit_serik;

  logic        Clock;
  logic        ResetN;
  logic        Start;
  logic        Sub;
  logic [15:0] OpA;
  logic [15:0] OpB;
  logic        FA_A, FA_B, FA_CIN;
  logic        FA_Shuma, FA_COUT;
  logic        Busy, Done;
  logic [15:0] Result;
  logic        COUT, Overflow, Zero;
  logic [1:0]  dbg_state_o;

  int checks;
  int errors;

  kontrolli_mbledhesit_serik #(.WIDTH(16)) dut (
    .Clock(Clock), .ResetN(ResetN), .Start(Start), .Sub(Sub),
    .OpA(OpA), .OpB(OpB),
    .FA_A(FA_A), .FA_B(FA_B), .FA_CIN(FA_CIN),
    .FA_Shuma(FA_Shuma), .FA_COUT(FA_COUT),
    .Busy(Busy), .Done(Done), .Result(Result),
    .COUT(COUT), .Overflow(Overflow), .Zero(Zero),
    .dbg_state_o(dbg_state_o)
  );

  assign FA_Shuma = FA_A ^ FA_B ^ FA_CIN;
  assign FA_COUT  = (FA_A & FA_B) | (FA_A & FA_CIN) | (FA_B & FA_CIN);

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Drive a request at a falling edge, let one rising edge sample it, then drop Start.
  task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic s);
    @(negedge Clock);
    OpA = a; OpB = b; Sub = s; Start = 1'b1;
    @(posedge Clock);
    #1 Start = 1'b0;
  endtask

  // Count rising edges until Done is seen on a falling edge. The wait is bounded to 40 edges.
  task automatic wait_done(output int edges, output int busy_cnt, output int zero_in_run);
    edges = 0; busy_cnt = 0; zero_in_run = 0;
    while (edges < 40) begin
      @(negedge Clock);
      if (Done) break;
      if (Busy) busy_cnt++;
      if (Zero) zero_in_run++;
      @(posedge Clock);
      edges++;
    end
  endtask

  task automatic test_reset();
    ResetN = 1'b0; Start = 1'b0; Sub = 1'b0; OpA = '0; OpB = '0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    ResetN = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clock);
      checks++;
      if ({Busy, Done, Result, COUT, Overflow, Zero, FA_A, FA_B, FA_CIN, dbg_state_o} !== '0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: busy=%b done=%b result=%h cout=%b ovf=%b zero=%b fa=%b%b%b st=%0d, all required 0",
                 i, Busy, Done, Result, COUT, Overflow, Zero, FA_A, FA_B, FA_CIN, dbg_state_o);
      end
    end
  endtask

  task automatic test_add();
    int edges, busy_cnt, zr;
    launch(16'h1234, 16'h0FFF, 1'b0);
    wait_done(edges, busy_cnt, zr);
    checks++; if (edges !== 16) begin errors++; $display("FAIL add_latency: got %0d edges, expected 16", edges); end
    checks++; if (busy_cnt !== 16) begin errors++; $display("FAIL add_busy: got %0d busy cycles, expected 16", busy_cnt); end
    checks++; if (zr !== 0) begin errors++; $display("FAIL add_zero_in_run: Zero high for %0d cycles, expected 0", zr); end
    checks++; if (Result !== 16'h2233) begin errors++; $display("FAIL add_result: got %h, expected 2233", Result); end
    checks++; if ({COUT, Overflow, Zero} !== 3'b000) begin errors++; $display("FAIL add_flags: got c/v/z=%b%b%b, expected 000", COUT, Overflow, Zero); end
    checks++; if ({FA_A, FA_B, FA_CIN} !== 3'b000) begin errors++; $display("FAIL add_cell_in_done: got %b%b%b, expected 000", FA_A, FA_B, FA_CIN); end
    @(negedge Clock);
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL add_done_pulse: Done=%b in second cycle, expected 0", Done); end
    checks++; if (Result !== 16'h2233 || dbg_state_o !== 2'd0) begin
      errors++; $display("FAIL add_hold: got result=%h st=%0d, expected 2233 st=0", Result, dbg_state_o);
    end
  endtask

  // Columns: a, b, sub, expected result, expected {cout, ovf, zero}.
  task automatic test_sub_and_flags();
    logic [15:0] va [7]; logic [15:0] vb [7]; logic vs [7];
    logic [15:0] er [7]; logic [2:0] ef [7];
    int edges, busy_cnt, zr;
    va[0] = 16'h0005; vb[0] = 16'h0007; vs[0] = 1; er[0] = 16'hFFFE; ef[0] = 3'b000;
    va[1] = 16'h0007; vb[1] = 16'h0005; vs[1] = 1; er[1] = 16'h0002; ef[1] = 3'b100;
    va[2] = 16'h7FFF; vb[2] = 16'h0001; vs[2] = 0; er[2] = 16'h8000; ef[2] = 3'b010;
    va[3] = 16'hFFFF; vb[3] = 16'h0001; vs[3] = 0; er[3] = 16'h0000; ef[3] = 3'b101;
    va[4] = 16'h8000; vb[4] = 16'h0001; vs[4] = 1; er[4] = 16'h7FFF; ef[4] = 3'b110;
    va[5] = 16'h1234; vb[5] = 16'h1234; vs[5] = 1; er[5] = 16'h0000; ef[5] = 3'b101;
    va[6] = 16'h8000; vb[6] = 16'h8000; vs[6] = 0; er[6] = 16'h0000; ef[6] = 3'b111;
    for (int i = 0; i < 7; i++) begin
      launch(va[i], vb[i], vs[i]);
      wait_done(edges, busy_cnt, zr);
      checks++;
      if (edges !== 16 || zr !== 0 || Result !== er[i] || {COUT, Overflow, Zero} !== ef[i]) begin
        errors++;
        $display("FAIL vec%0d %h%s%h: got edges=%0d zero_in_run=%0d result=%h cvz=%b, expected edges=16 zero_in_run=0 result=%h cvz=%b",
                 i, va[i], vs[i] ? "-" : "+", vb[i], edges, zr, Result, {COUT, Overflow, Zero}, er[i], ef[i]);
      end
    end
  endtask

  task automatic test_start_ignored();
    int edges, busy_cnt, zr;
    launch(16'h00F0, 16'h000F, 1'b0);
    Start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      OpA = 16'hFFFF - 16'(i); OpB = 16'h5555; Sub = 1'b1;
    end
    Start = 1'b0;
    wait_done(edges, busy_cnt, zr);
    checks++; if (edges !== 6) begin errors++; $display("FAIL ignore_latency: got %0d remaining edges, expected 6", edges); end
    checks++; if (Result !== 16'h00FF || {COUT, Overflow, Zero} !== 3'b000) begin
      errors++; $display("FAIL ignore_result: got %h cvz=%b, expected 00FF cvz=000", Result, {COUT, Overflow, Zero});
    end
  endtask

  task automatic test_back_to_back();
    int edges, busy_cnt, zr;
    launch(16'h1111, 16'h2222, 1'b0);
    wait_done(edges, busy_cnt, zr);
    checks++; if (Result !== 16'h3333 || edges !== 16) begin
      errors++; $display("FAIL b2b_first: got %h after %0d edges, expected 3333 after 16", Result, edges);
    end
    OpA = 16'h0100; OpB = 16'h0001; Sub = 1'b1; Start = 1'b1;
    @(posedge Clock);
    #1 Start = 1'b0;
    wait_done(edges, busy_cnt, zr);
    checks++; if (edges + 1 !== 17) begin errors++; $display("FAIL b2b_gap: got %0d cycles between Done pulses, expected 17", edges + 1); end
    checks++; if (Result !== 16'h00FF || {COUT, Overflow, Zero} !== 3'b100) begin
      errors++; $display("FAIL b2b_second: got %h cvz=%b, expected 00FF cvz=100", Result, {COUT, Overflow, Zero});
    end
  endtask

  task automatic test_reset_mid_op();
    int edges, busy_cnt, zr, done_seen;
    launch(16'hABCD, 16'h1111, 1'b0);
    repeat (7) @(posedge Clock);
    #2 ResetN = 1'b0;
    #1;
    checks++;
    if ({Busy, Done, Result, COUT, Overflow, Zero, FA_A, FA_B, FA_CIN, dbg_state_o} !== '0) begin
      errors++;
      $display("FAIL midreset_clear: busy=%b done=%b result=%h cvz=%b%b%b fa=%b%b%b st=%0d, all required 0",
               Busy, Done, Result, COUT, Overflow, Zero, FA_A, FA_B, FA_CIN, dbg_state_o);
    end
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    ResetN = 1'b1;
    done_seen = 0;
    repeat (25) begin
      @(negedge Clock);
      if (Done || Busy) done_seen++;
    end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL midreset_no_done: got %0d active cycles, expected 0", done_seen); end
    launch(16'hABCD, 16'h1111, 1'b0);
    wait_done(edges, busy_cnt, zr);
    checks++; if (edges !== 16 || Result !== 16'hBCDE || {COUT, Overflow, Zero} !== 3'b000) begin
      errors++; $display("FAIL midreset_recover: got %h cvz=%b after %0d edges, expected BCDE cvz=000 after 16",
                         Result, {COUT, Overflow, Zero}, edges);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add();
    test_sub_and_flags();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
